// File: rtl/game_pkg.sv
// Shared types and helpers for the Flappy Bruin game-flow controller.
//   game_state_t : FSM phase encoding, exported on the state port
//   BCD_W        : bits per BCD digit
//   bcd_inc      : saturating BCD increment over the low `digits` digits
//   bcd_gt       : magnitude compare of two packed BCD values
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    HIT   = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX_DIGITS = 8;

  // Ripple a +1 through the digits; an all-9s value is returned unchanged.
  function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] bcd_inc(
    input logic [BCD_W*BCD_MAX_DIGITS-1:0] v,
    input int                              digits
  );
    logic [BCD_W*BCD_MAX_DIGITS-1:0] r;
    logic                            carry;
    logic                            all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        if (v[i*BCD_W +: BCD_W] != 4'd9) all9 = 1'b0;
        if (carry) begin
          if (v[i*BCD_W +: BCD_W] == 4'd9) begin
            r[i*BCD_W +: BCD_W] = 4'd0;
          end else begin
            r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + 4'd1;
            carry               = 1'b0;
          end
        end
      end
    end
    return all9 ? v : r;
  endfunction

  // Valid BCD digits keep their numeric order, so packed BCD compares as
  // a plain unsigned number.
  function automatic logic bcd_gt(
    input logic [BCD_W*BCD_MAX_DIGITS-1:0] a,
    input logic [BCD_W*BCD_MAX_DIGITS-1:0] b
  );
    return a > b;
  endfunction

endpackage

// File: rtl/flap_debounce.sv
// Flap button conditioning: 2-flop synchronizer, frame-rate sampling debounce
// and a registered rising-edge pulse.
//   clk_100MHz : system clock
//   rst_n      : asynchronous active-low reset
//   btn        : raw asynchronous button
//   frame_tick : one-cycle sample strobe
//   flap       : debounced level, changes after DEBOUNCE_FRAMES equal samples
//   flap_pulse : one cycle, coincident with the flap 0->1 edge
module flap_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic btn,
  input  logic frame_tick,
  output logic flap,
  output logic flap_pulse
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic          sync1_q, sync2_q;
  logic          samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flap_q, flap_d;
  logic          pulse_q;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this combinational block latch-free.
  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    flap_d = flap_q;
    if (frame_tick) begin
      samp_d = sync2_q;
      if (sync2_q != samp_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CW'(DEBOUNCE_FRAMES)) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CW'(DEBOUNCE_FRAMES)) flap_d = sync2_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; sync2_q must see the old sync1_q.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp_q  <= 1'b0;
      cnt_q   <= '0;
      flap_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      flap_q  <= flap_d;
      pulse_q <= flap_d & ~flap_q;
    end
  end

  assign flap       = flap_q;
  assign flap_pulse = pulse_q;

endmodule

// File: rtl/game_sequencer.sv
// Flappy Bruin game-flow controller: 60 Hz frame divider, flap debounce,
// IDLE/READY/PLAY/HIT/OVER sequencing and BCD score keeping.
//   inputs : clk_100MHz, rst_n (async, active low), btn, pipe_passed,
//            collide, floor_hit
//   outputs: frame_tick, flap, flap_pulse, game_start, lose, state,
//            score, high_score, new_record
// Build option: define GAME_HISCORE_EN to keep a high score across games;
// otherwise high_score and new_record are tied to 0.
module game_sequencer
  import game_pkg::*;
#(
  parameter int FRAME_DIV       = 1_666_667,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int READY_FRAMES    = 60,
  parameter int HIT_FRAMES      = 90,
  parameter int SCORE_DIGITS    = 3
) (
  input  logic                          clk_100MHz,
  input  logic                          rst_n,
  input  logic                          btn,
  input  logic                          pipe_passed,
  input  logic                          collide,
  input  logic                          floor_hit,
  output logic                          frame_tick,
  output logic                          flap,
  output logic                          flap_pulse,
  output logic                          game_start,
  output logic                          lose,
  output logic [2:0]                    state,
  output logic [BCD_W*SCORE_DIGITS-1:0] score,
  output logic [BCD_W*SCORE_DIGITS-1:0] high_score,
  output logic                          new_record
);

  localparam int SW     = BCD_W * SCORE_DIGITS;
  localparam int DIV_W  = $clog2(FRAME_DIV + 1);
  localparam int PH_MAX = (READY_FRAMES > HIT_FRAMES) ? READY_FRAMES : HIT_FRAMES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int FW     = BCD_W * BCD_MAX_DIGITS;

  logic [DIV_W-1:0] div_q;
  logic             tick_q;
  game_state_t      state_q, state_d;
  logic [PH_W-1:0]  phase_q;
  logic             start_q, start_d;
  logic             lose_q, lose_d;
  logic [SW-1:0]    score_q;
  logic             flap_pulse_w;
  logic             hit_w;
  logic             enter_hit;
  logic             enter_ready;

  // Frame divider: the tick is high in the cycle the count is back at 0.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
      div_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      div_q  <= div_q + DIV_W'(1);
      tick_q <= 1'b0;
    end
  end

  flap_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_flap (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .btn       (btn),
    .frame_tick(tick_q),
    .flap      (flap),
    .flap_pulse(flap_pulse_w)
  );

  assign hit_w = collide | floor_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (flap_pulse_w) state_d = READY;
      READY: if (tick_q && phase_q == PH_W'(READY_FRAMES - 1)) state_d = PLAY;
      PLAY:  if (hit_w) state_d = HIT;
      HIT:   if (tick_q && phase_q == PH_W'(HIT_FRAMES - 1)) state_d = OVER;
      OVER:  if (flap_pulse_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Enables are registered from the next state so they leave flops directly.
    start_d = (state_d == PLAY) || (state_d == HIT) || (state_d == OVER);
    lose_d  = (state_d == HIT) || (state_d == OVER);
  end

  assign enter_hit   = (state_q == PLAY) && (state_d == HIT);
  assign enter_ready = (state_q == IDLE) && (state_d == READY);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      lose_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      lose_q  <= lose_d;
      if (state_d != state_q) begin
        phase_q <= '0;
      end else if (tick_q && (state_q == READY || state_q == HIT)) begin
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

  // A hit in the same cycle as pipe_passed suppresses the increment.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (enter_ready) begin
      score_q <= '0;
    end else if (state_q == PLAY && pipe_passed && !hit_w) begin
      score_q <= SW'(bcd_inc(FW'(score_q), SCORE_DIGITS));
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SW-1:0] high_q;
  logic          record_q;

  // The score is frozen on the hit cycle, so it is final at HIT entry.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      high_q   <= '0;
      record_q <= 1'b0;
    end else if (enter_hit && bcd_gt(FW'(score_q), FW'(high_q))) begin
      high_q   <= score_q;
      record_q <= 1'b1;
    end else if (enter_ready) begin
      record_q <= 1'b0;
    end
  end

  assign high_score = high_q;
  assign new_record = record_q;
`else
  assign high_score = '0;
  assign new_record = 1'b0;
`endif

  assign frame_tick = tick_q;
  assign flap_pulse = flap_pulse_w;
  assign game_start = start_q;
  assign lose       = lose_q;
  assign state      = state_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a short frame (FRAME_DIV=10).
// A reference score model pushes expected BCD scores to a queue as each
// pipe_passed is driven; the entry is popped when the DUT has registered it.
module tb_game_sequencer;
  import game_pkg::*;

  logic        clk_100MHz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        btn        = 1'b0;
  logic        pipe_passed = 1'b0;
  logic        collide    = 1'b0;
  logic        floor_hit  = 1'b0;
  logic        frame_tick, flap, flap_pulse, game_start, lose, new_record;
  logic [2:0]  state;
  logic [11:0] score, high_score;

  int total = 0;
  int bad   = 0;

  int          exp_score = 0;
  int          exp_hi    = 0;
  logic        exp_rec   = 1'b0;
  logic        in_play   = 1'b0;
  logic [11:0] exp_q[$];

  always #5 clk_100MHz = ~clk_100MHz;

  game_sequencer #(
    .FRAME_DIV(10)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .btn        (btn),
    .pipe_passed(pipe_passed),
    .collide    (collide),
    .floor_hit  (floor_hit),
    .frame_tick (frame_tick),
    .flap       (flap),
    .flap_pulse (flap_pulse),
    .game_start (game_start),
    .lose       (lose),
    .state      (state),
    .score      (score),
    .high_score (high_score),
    .new_record (new_record)
  );

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [11:0] exp_hs();
`ifdef GAME_HISCORE_EN
    return to_bcd(exp_hi);
`else
    return 12'h000;
`endif
  endfunction

  function automatic logic exp_nr();
`ifdef GAME_HISCORE_EN
    return exp_rec;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic model_hit();
    if (exp_score > exp_hi) begin
      exp_hi  = exp_score;
      exp_rec = 1'b1;
    end
    in_play = 1'b0;
  endtask

  // Advance until state==target; counts frame ticks seen on the way.
  task automatic run_until(input game_state_t target, input int budget, output int ticks);
    logic found;
    found = 1'b0;
    ticks = 0;
    for (int c = 0; c < budget && !found; c++) begin
      if (state == target) found = 1'b1;
      else begin
        if (frame_tick) ticks++;
        step();
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_state: got %0d want %0d", state, target);
    end
  endtask

  task automatic press_until(input game_state_t target);
    int t;
    btn = 1'b1;
    run_until(target, 80, t);
    btn = 1'b0;
    if (target == READY) begin
      exp_score = 0;
      exp_rec   = 1'b0;
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_score = 0;
    exp_hi    = 0;
    exp_rec   = 1'b0;
    in_play   = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_pipe(input logic hit);
    logic [11:0] want;
    pipe_passed = 1'b1;
    floor_hit   = hit;
    if (in_play && hit) model_hit();
    else if (in_play && exp_score < 999) exp_score++;
    exp_q.push_back(to_bcd(exp_score));
    step();
    pipe_passed = 1'b0;
    floor_hit   = 1'b0;
    want = exp_q.pop_front();
    total++;
    if (score !== want) begin
      bad++;
      $display("FAIL score: got %h want %h", score, want);
    end
    step();
    total++;
    if (high_score !== exp_hs()) begin
      bad++;
      $display("FAIL high_score_pipe: got %h want %h", high_score, exp_hs());
    end
  endtask

  task automatic do_collide();
    collide = 1'b1;
    model_hit();
    step();
    collide = 1'b0;
    total++;
    if (state !== HIT || lose !== 1'b1 || game_start !== 1'b1) begin
      bad++;
      $display("FAIL hit_entry: got st=%0d lose=%b gs=%b want st=3 lose=1 gs=1",
               state, lose, game_start);
    end
    step();
    total++;
    if (high_score !== exp_hs() || new_record !== exp_nr()) begin
      bad++;
      $display("FAIL hiscore: got hs=%h nr=%b want hs=%h nr=%b",
               high_score, new_record, exp_hs(), exp_nr());
    end
  endtask

  task automatic start_game();
    int t;
    press_until(READY);
    total++;
    if (score !== 12'h000 || new_record !== 1'b0 || game_start !== 1'b0) begin
      bad++;
      $display("FAIL ready_entry: got sc=%h nr=%b gs=%b want 000 0 0",
               score, new_record, game_start);
    end
    run_until(PLAY, 1000, t);
    total++;
    if (t != 60) begin
      bad++;
      $display("FAIL ready_len: got %0d ticks want 60", t);
    end
    total++;
    if (game_start !== 1'b1 || lose !== 1'b0) begin
      bad++;
      $display("FAIL play_out: got gs=%b lose=%b want 1 0", game_start, lose);
    end
    in_play = 1'b1;
  endtask

  task automatic finish_game();
    int t;
    run_until(OVER, 1200, t);
    total++;
    if (t != 90 || lose !== 1'b1) begin
      bad++;
      $display("FAIL hit_len: got %0d ticks lose=%b want 90 1", t, lose);
    end
    press_until(IDLE);
    total++;
    if (game_start !== 1'b0 || lose !== 1'b0) begin
      bad++;
      $display("FAIL idle_out: got gs=%b lose=%b want 0 0", game_start, lose);
    end
    repeat (50) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({frame_tick, flap, flap_pulse, game_start, lose, new_record} !== 6'b0 ||
        state !== IDLE || score !== 12'h0 || high_score !== 12'h0) begin
      bad++;
      $display("FAIL reset_out: got st=%0d sc=%h hs=%h", state, score, high_score);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if (frame_tick !== (i == 10)) begin
        bad++;
        $display("FAIL first_tick: cycle %0d got %b want %b", i, frame_tick, i == 10);
      end
    end
    total++;
    if (state !== IDLE || game_start !== 1'b0 || lose !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got st=%0d", state);
    end
  endtask

  task automatic test_debounce();
    int   pulses;
    int   rise;
    logic prev;
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      btn = (c < 10);
      step();
      if (flap_pulse) pulses++;
    end
    total++;
    if (pulses != 0 || flap !== 1'b0 || state !== IDLE) begin
      bad++;
      $display("FAIL short_press: got pulses=%0d flap=%b st=%0d want 0 0 0",
               pulses, flap, state);
    end
    pulses = 0;
    rise   = -1;
    prev   = flap;
    for (int c = 0; c < 110; c++) begin
      btn = (c < 50);
      step();
      if (flap_pulse) begin
        pulses++;
        total++;
        if (!(flap && !prev)) begin
          bad++;
          $display("FAIL pulse_align: got flap=%b prev=%b want 1 0", flap, prev);
        end
      end
      if (flap && rise < 0) rise = c;
      prev = flap;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL long_press_pulses: got %0d want 1", pulses);
    end
    total++;
    if (rise < 0 || rise >= 40) begin
      bad++;
      $display("FAIL flap_latency: got %0d cycles want <40", rise);
    end
    total++;
    if (flap !== 1'b0 || state !== READY) begin
      bad++;
      $display("FAIL after_release: got flap=%b st=%0d want 0 1", flap, state);
    end
    do_reset();
  endtask

  task automatic test_score_collision();
    start_game();
    for (int i = 0; i < 12; i++) send_pipe(1'b0);
    total++;
    if (score !== 12'h012) begin
      bad++;
      $display("FAIL score12: got %h want 012", score);
    end
    do_collide();
    finish_game();
  endtask

  task automatic test_simultaneous();
    start_game();
    for (int i = 0; i < 5; i++) send_pipe(1'b0);
    send_pipe(1'b1);
    total++;
    if (state !== HIT || score !== 12'h005 || new_record !== exp_nr()) begin
      bad++;
      $display("FAIL simul: got st=%0d sc=%h nr=%b want 3 005 %b",
               state, score, new_record, exp_nr());
    end
    send_pipe(1'b0);
    finish_game();
  endtask

  task automatic test_saturation_and_reset();
    start_game();
    for (int i = 0; i < 998; i++) send_pipe(1'b0);
    total++;
    if (score !== 12'h998) begin
      bad++;
      $display("FAIL score998: got %h want 998", score);
    end
    for (int i = 0; i < 3; i++) send_pipe(1'b0);
    total++;
    if (score !== 12'h999) begin
      bad++;
      $display("FAIL saturate: got %h want 999", score);
    end
    do_collide();
    // Reset asserted between clock edges must act without an edge.
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (state !== IDLE || high_score !== 12'h0 || score !== 12'h0 ||
        lose !== 1'b0 || game_start !== 1'b0 || new_record !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got st=%0d hs=%h sc=%h lose=%b", state, high_score, score, lose);
    end
    step();
    rst_n = 1'b1;
    repeat (5) step();
    total++;
    if (state !== IDLE || high_score !== 12'h0) begin
      bad++;
      $display("FAIL post_reset: got st=%0d hs=%h", state, high_score);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_score_collision();
    test_simultaneous();
    test_saturation_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for Flappy Bruin. Runs in the 100 MHz domain, generates the 60 Hz frame tick, debounces the flap button, and sequences the game through idle, countdown, play, hit and game-over phases. Drives the `game_start`/`lose` enables consumed by the bruin and pipe datapaths, and keeps BCD score and high score for the display.

## Interface
- `FRAME_DIV`, 1_666_667: `clk_100MHz` cycles per frame (60 Hz).
- `DEBOUNCE_FRAMES`, 3: consecutive equal frame samples needed to change `flap`.
- `READY_FRAMES`, 60: countdown length in frames.
- `HIT_FRAMES`, 90: freeze length after a hit, in frames.
- `SCORE_DIGITS`, 3: BCD digits of score and high score.

Ports:
- `clk_100MHz`  in  1: only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn`  in  1: raw, asynchronous flap button.
- `pipe_passed`  in  1: one-cycle pulse when the bruin clears a pipe.
- `collide`  in  1: level, bruin overlaps a pipe.
- `floor_hit`  in  1: level, bruin reached the bottom limit.
- `frame_tick`  out  1: one-cycle pulse every `FRAME_DIV` cycles.
- `flap`  out  1: debounced button level.
- `flap_pulse`  out  1: one-cycle pulse on a `flap` rising edge.
- `game_start`  out  1: datapaths may advance.
- `lose`  out  1: datapaths freeze.
- `state`  out  3: current `game_state_t` encoding.
- `score`  out  4*SCORE_DIGITS: BCD score.
- `high_score`  out  4*SCORE_DIGITS: BCD best score.
- `new_record`  out  1: the last game set a new high score.

## Operation
- **Frame counter:** counts 0..FRAME_DIV-1. `frame_tick`=1 in the cycle the count wraps to 0.
- **Button synchronizer and debounce:**
  - `btn` passes through a 2-flop synchronizer.
  - The synchronized value is sampled on `frame_tick`.
  - `flap` takes the sampled value after `DEBOUNCE_FRAMES` consecutive identical samples.
  - `flap_pulse`=1 in the cycle `flap` goes 0→1.
- **FSM states:** IDLE, READY, PLAY, HIT, OVER.
- **IDLE:**
  - Outputs: `game_start`=0, `lose`=0.
  - `flap_pulse` → READY. On that transition `score` clears to 0 and `new_record` clears.
- **READY:**
  - Outputs: `game_start`=0, `lose`=0.
  - A frame counter counts `frame_tick`s. After `READY_FRAMES` ticks → PLAY.
  - `flap_pulse` in READY is ignored.
- **PLAY:**
  - Outputs: `game_start`=1, `lose`=0.
  - `collide|floor_hit` → HIT.
  - Otherwise `pipe_passed` increments `score` as BCD with per-digit carry, saturating at all 9s.
- **HIT:**
  - Outputs: `game_start`=1, `lose`=1.
  - On entry, if `score > high_score` (BCD compare), then `high_score<=score` and `new_record<=1`.
  - After `HIT_FRAMES` ticks → OVER.
- **OVER:**
  - Outputs: `game_start`=1, `lose`=1.
  - `flap_pulse` → IDLE.
- **Simultaneous events:**
  - In PLAY, `pipe_passed` and `collide`/`floor_hit` in the same cycle: the hit wins and the score is not incremented.
  - `pipe_passed` outside PLAY is ignored.
- **Frame counter within a phase:** the phase frame counter clears on every state transition.

## Timing
- Reset (`rst_n`=0, any time, including mid-game) takes effect immediately, with no clock needed:
  - state = IDLE;
  - `frame_tick`, `flap`, `flap_pulse`, `game_start`, `lose`, `new_record` = 0;
  - `score` and `high_score` = 0;
  - all counters and synchronizer flops = 0.
- The first `frame_tick` occurs `FRAME_DIV` cycles after reset release.
- Press to `flap` latency: 2 cycles of synchronization, plus up to `DEBOUNCE_FRAMES`+1 frames of sampling. `flap_pulse` is registered and lands in the same cycle `flap` rises.
- State transitions are registered:
  - outputs reflect the new state 1 cycle after the triggering input;
  - `game_start`/`lose` come straight from state flops, glitch-free.
- The score increment is visible 1 cycle after `pipe_passed`. The `high_score` update is visible 1 cycle after entering HIT.
- READY→PLAY occurs in the cycle after the `READY_FRAMES`-th `frame_tick` after entering READY.

## Configuration
- `GAME_HISCORE_EN` defined:
  - `high_score` register and compare logic are present;
  - `high_score` survives across games and is cleared only by `rst_n`.
- `GAME_HISCORE_EN` undefined:
  - no high-score register;
  - `high_score` is tied to 0 and `new_record` to 0;
  - all other behaviour is unchanged.

## Structure
- Package `game_pkg` holds:
  - the `game_state_t` enum (IDLE=0, READY=1, PLAY=2, HIT=3, OVER=4);
  - localparam `BCD_W`=4;
  - a BCD increment/compare function shared with the score display.
- Sub-module `flap_debounce` holds the synchronizer, the frame-sampled debounce and the edge pulse. Its ports are clk_100MHz, rst_n, btn, frame_tick, flap, flap_pulse.
- The top level holds the frame divider, the FSM, the phase counter and the score registers.

## Test plan
Benches use `FRAME_DIV`=10 for speed.
- **Reset values:** reset, release, wait 10 cycles → `frame_tick` pulses exactly at cycle 10; state=IDLE; all outputs 0.
- **Button debounce:** hold `btn`=1 for 1 frame, then 0 → no `flap_pulse`. Hold `btn`=1 for 5 frames → exactly one `flap_pulse`, and `flap`=1 within 4 frames.
- **Score and collision:** press, wait `READY_FRAMES` → state=PLAY, `game_start`=1. Send 12 `pipe_passed` → `score`=0x012. Assert `collide` → HIT, `lose`=1, `high_score`=0x012, `new_record`=1.
- **Simultaneous pipe and hit:** in PLAY with `score`=0x005, assert `pipe_passed` and `floor_hit` in the same cycle → HIT, `score` stays 0x005.
- **Score saturation:** from `score`=0x998, send 3 `pipe_passed` → 0x999 and it holds.
- **Mid-game reset:** with state=HIT, pulse `rst_n` low for 1 cycle → state=IDLE, `high_score`=0 immediately. Without `GAME_HISCORE_EN`, `high_score` stays 0 throughout the score-and-collision scenario.
